lcd_cmd_scheduler: RTL and testbench



---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_cmd_scheduler_timer.sv | 25 ++
 rtl/lcd_cmd_scheduler.sv | 142 ++++++++++++++
 tb/tb_lcd_cmd_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the 1602A LCD command path:
// instruction bytes, default timing, FSM states and the init ROM.
package lcd_pkg;

   localparam logic [7:0] LCD_SETUP   = 8'h28;
   localparam logic [7:0] LCD_DISP_ON = 8'h0C;
   localparam logic [7:0] LCD_CLEAR   = 8'h01;
   localparam logic [7:0] LCD_ENTRY_N = 8'h06;
   localparam logic [7:0] LCD_HOME    = 8'h02;
   localparam logic [7:0] LCD_SHIFT_L = 8'h18;
   localparam logic [7:0] LCD_SHIFT_R = 8'h1C;

   localparam int T_SHORT_DEF = 1008;
   localparam int T_LONG_DEF  = 39360;
   localparam int T_PWRUP_DEF = 360000;
   localparam int CNT_W_DEF   = 20;

   typedef enum logic [2:0] {
      PWRUP,
      INIT_ISSUE,
      INIT_BUSY,
      INIT_WAIT,
      IDLE,
      ISSUE,
      BUSY,
      EXEC_WAIT
   } state_t;

   function automatic logic [7:0] init_rom(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = LCD_SETUP;
         2'd1:    b = LCD_DISP_ON;
         2'd2:    b = LCD_CLEAR;
         default: b = LCD_ENTRY_N;
      endcase
      return b;
   endfunction

   // CLEAR and HOME (and 0x00) need the long execution time
   function automatic logic is_long(input logic rs, input logic [7:0] d);
      return !rs && (d[7:2] == 6'd0);
   endfunction

endpackage

// File: rtl/lcd_cmd_scheduler_timer.sv
// Loadable down counter; done while the count sits at zero.
module lcd_delay_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Runs the HD44780 init sequence, then round-robins command and
// character requesters onto the byte driver with exec delays.
module lcd_cmd_scheduler
   import lcd_pkg::*;
#(
   parameter int T_SHORT = T_SHORT_DEF,
   parameter int T_LONG  = T_LONG_DEF,
   parameter int T_PWRUP = T_PWRUP_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   input  logic [7:0] req_cmd,
   input  logic [7:0] req_char,
   output logic [1:0] req_ready,
   output logic       drv_en,
   output logic       drv_rs,
   output logic [7:0] drv_data,
   input  logic       drv_rdy,
   output logic       init_done,
   output logic       busy
);

   state_t           state, state_n;
   logic [1:0]       idx;
   logic             armed;
   logic             ptr;
   logic             pend_rs;
   logic [7:0]       pend_data;
   logic             gnt;
   logic             gnt_v;
   logic             t_load;
   logic [CNT_W-1:0] t_val;
   logic [CNT_W-1:0] exec_val;
   logic             t_done;

   lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .done     (t_done)
   );

   assign exec_val = is_long(drv_rs, drv_data) ?
                     CNT_W'(T_LONG) : CNT_W'(T_SHORT);
   assign gnt_v = (state == IDLE) && (req_valid != 2'b00);
   assign busy  = (state != IDLE);

   always_comb begin
      gnt = 1'b0;
      case (req_valid)
         2'b10:   gnt = 1'b1;
         2'b11:   gnt = ptr;
         default: gnt = 1'b0;
      endcase
   end

   always_comb begin
      state_n   = state;
      t_load    = 1'b0;
      t_val     = '0;
      req_ready = 2'b00;
      case (state)
         PWRUP:
            if (!armed) begin
               t_load = 1'b1;
               t_val  = CNT_W'(T_PWRUP);
            end else if (t_done) begin
               state_n = INIT_ISSUE;
            end
         INIT_ISSUE:
            if (drv_rdy) state_n = INIT_BUSY;
         // drv_en high marks the cycle where drv_rdy is still stale
         INIT_BUSY:
            if (!drv_en && drv_rdy) begin
               t_load  = 1'b1;
               t_val   = exec_val;
               state_n = INIT_WAIT;
            end
         INIT_WAIT:
            if (t_done) state_n = (idx == 2'd3) ? IDLE : INIT_ISSUE;
         IDLE:
            if (gnt_v) begin
               req_ready[gnt] = 1'b1;
               state_n        = ISSUE;
            end
         ISSUE:
            if (drv_rdy) state_n = BUSY;
         BUSY:
            if (!drv_en && drv_rdy) begin
               t_load  = 1'b1;
               t_val   = exec_val;
               state_n = EXEC_WAIT;
            end
         EXEC_WAIT:
            if (t_done) state_n = IDLE;
         default:
            state_n = PWRUP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PWRUP;
         armed     <= 1'b0;
         idx       <= 2'd0;
         ptr       <= 1'b0;
         init_done <= 1'b0;
         pend_rs   <= 1'b0;
         pend_data <= 8'h00;
         drv_en    <= 1'b0;
         drv_rs    <= 1'b0;
         drv_data  <= 8'h00;
      end else begin
         state  <= state_n;
         drv_en <= 1'b0;
         if (state == PWRUP) armed <= 1'b1;
         if (state == INIT_WAIT && t_done) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) init_done <= 1'b1;
         end
         if (state == INIT_ISSUE && drv_rdy) begin
            drv_en   <= 1'b1;
            drv_rs   <= 1'b0;
            drv_data <= init_rom(idx);
         end
         if (state == ISSUE && drv_rdy) begin
            drv_en   <= 1'b1;
            drv_rs   <= pend_rs;
            drv_data <= pend_data;
         end
         if (gnt_v) begin
            pend_rs   <= gnt;
            pend_data <= gnt ? req_char : req_cmd;
            ptr       <= ~gnt;
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Scoreboard bench for lcd_cmd_scheduler with a behavioural
// byte driver and scaled-down timing.
module tb_lcd_cmd_scheduler;

   localparam int TS = 20;
   localparam int TL = 100;
   localparam int TP = 300;
   localparam int CW = 12;
   localparam int SLACK = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [7:0] req_cmd;
   logic [7:0] req_char;
   logic [1:0] req_ready;
   logic       drv_en;
   logic       drv_rs;
   logic [7:0] drv_data;
   logic       drv_rdy;
   logic       init_done;
   logic       busy;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         min_gap;
      logic       init;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   wr_time = 4;
   int   m_cyc;
   int   m_rise;
   logic m_prev;

   lcd_cmd_scheduler #(
      .T_SHORT (TS),
      .T_LONG  (TL),
      .T_PWRUP (TP),
      .CNT_W   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_cmd   (req_cmd),
      .req_char  (req_char),
      .req_ready (req_ready),
      .drv_en    (drv_en),
      .drv_rs    (drv_rs),
      .drv_data  (drv_data),
      .drv_rdy   (drv_rdy),
      .init_done (init_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic rs, input logic [7:0] d,
                       input int g, input logic i);
      exp_t e;
      e.rs = rs;
      e.data = d;
      e.min_gap = g;
      e.init = i;
      sb.push_back(e);
   endtask

   task automatic push_init();
      push(1'b0, 8'h28, TP, 1'b0);
      push(1'b0, 8'h0C, TS, 1'b0);
      push(1'b0, 8'h01, TS, 1'b0);
      push(1'b0, 8'h06, TL, 1'b0);
   endtask

   task automatic wait_accepts(input int n, input int limit);
      int k = 0;
      int t = 0;
      while (k < n && t < limit) begin
         @(negedge clk);
         t++;
         if (|(req_valid & req_ready)) k++;
      end
      check("accept_count", k, n);
   endtask

   task automatic wait_drain(input int limit);
      int t = 0;
      while (sb.size() != 0 && t < limit) begin
         @(negedge clk);
         t++;
      end
      check("scoreboard_drain", sb.size(), 0);
   endtask

   task automatic send(input logic [1:0] v, input logic [7:0] b,
                       input int g);
      push(v[1], b, g, 1'b1);
      if (v[1]) req_char = b;
      else req_cmd = b;
      req_valid = v;
      wait_accepts(1, 3000);
      @(posedge clk);
      #1 req_valid = 2'b00;
   endtask

   // byte driver: busy from the cycle after drv_en for wr_time cycles
   initial begin
      drv_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (drv_en && !rst) begin
            @(posedge clk);
            #1 drv_rdy = 1'b0;
            repeat (wr_time) @(posedge clk);
            #1 drv_rdy = 1'b1;
         end
      end
   end

   // monitor: pops on every drv_en, checks byte, gap and init_done
   initial begin
      exp_t e;
      int   gap;
      m_cyc = 0;
      m_rise = 0;
      m_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_cyc = 0;
            m_rise = 0;
            m_prev = drv_rdy;
         end else begin
            m_cyc++;
            if (drv_rdy && !m_prev) m_rise = m_cyc;
            m_prev = drv_rdy;
            if (req_ready != 2'b00)
               check("ready_gate", {busy, init_done}, 2'b01);
            if (drv_en) begin
               if (sb.size() == 0) begin
                  check("unexpected_en", {drv_rs, drv_data}, 9'h1FF);
               end else begin
                  e = sb.pop_front();
                  check("issue_byte", {drv_rs, drv_data}, {e.rs, e.data});
                  check("issue_init_done", init_done, e.init);
                  gap = m_cyc - m_rise;
                  n_chk++;
                  if (gap < e.min_gap || gap > e.min_gap + SLACK) begin
                     n_fail++;
                     $display("FAIL issue_gap: got %0d cycles need %0d..%0d",
                              gap, e.min_gap, e.min_gap + SLACK);
                  end
               end
            end
         end
      end
   end

   initial begin
      int bad;
      int t;
      rst = 1'b1;
      req_valid = 2'b11;
      req_cmd = 8'h0C;
      req_char = 8'h41;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_drv_en", drv_en, 1'b0);
      check("rst_drv_rs", drv_rs, 1'b0);
      check("rst_drv_data", drv_data, 8'h00);
      check("rst_init_done", init_done, 1'b0);
      check("rst_busy", busy, 1'b1);

      // init, then alternating grants starting at requester 0
      push_init();
      push(1'b0, 8'h0C, TS, 1'b1);
      push(1'b1, 8'h41, TS, 1'b1);
      push(1'b0, 8'h0C, TS, 1'b1);
      push(1'b1, 8'h41, TS, 1'b1);
      rst = 1'b0;
      wait_accepts(4, 5000);
      @(posedge clk);
      #1 req_valid = 2'b00;

      // CLEAR forces the long wait before the next byte; 0x06 does not
      send(2'b01, 8'h01, TS);
      send(2'b10, 8'h48, TL);
      send(2'b01, 8'h06, TS);
      send(2'b10, 8'h48, TS);
      wait_drain(3000);

      // slow driver; lone requester 1 wins against the pointer
      wr_time = 500;
      push(1'b1, 8'h41, TS, 1'b1);
      req_char = 8'h41;
      req_valid = 2'b10;
      wait_accepts(1, 3000);
      @(posedge clk);
      #1;
      push(1'b0, 8'h0C, TS, 1'b1);
      req_cmd = 8'h0C;
      req_valid = 2'b01;
      t = 0;
      while (drv_rdy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("slow_rdy_drop", drv_rdy, 1'b0);
      bad = 0;
      repeat (450) begin
         @(negedge clk);
         if (drv_en || !busy) bad++;
      end
      check("slow_hold_busy", bad, 0);
      wr_time = 4;
      wait_accepts(1, 3000);
      @(posedge clk);
      #1 req_valid = 2'b00;
      wait_drain(3000);

      // reset during EXEC_WAIT reruns the whole init
      send(2'b01, 8'h0C, TS);
      wait_drain(1000);
      t = 0;
      while (!drv_rdy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("pre_rst_rdy", drv_rdy, 1'b1);
      repeat (5) @(posedge clk);
      req_valid = 2'b11;
      #1 rst = 1'b1;
      #1;
      check("midrst_init_done", init_done, 1'b0);
      check("midrst_drv_en", drv_en, 1'b0);
      check("midrst_busy", busy, 1'b1);
      check("midrst_req_ready", req_ready, 2'b00);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (drv_en || req_ready != 2'b00) bad++;
      end
      check("midrst_hold", bad, 0);
      push_init();
      push(1'b0, 8'h0C, TS, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_accepts(1, 5000);
      @(posedge clk);
      #1 req_valid = 2'b00;
      wait_drain(1000);
      check("final_init_done", init_done, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
